// File: rtl/alu_seq.sv
// alu_seq: multi-cycle, width-parameterised successor to the 6502 ALU.
// Takes an operation over a valid/ready handshake, computes it, and holds
// the result, the {N,V,Z,C} flags and a per-op flag-write mask until the
// consumer takes them.
// Optional build macro ALU_BCD_EN: adds the decimal ADC/SBC path, which
// adjusts one nibble per cycle in the BCD state. Without it dec_mode is
// ignored and every operation finishes with binary latency.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int FUNC_W = 4
) (
  input  logic              phi1,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [FUNC_W-1:0] func,
  input  logic              carry_in,
  input  logic              dec_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  dout,
  output logic [3:0]        flags,
  output logic [3:0]        flag_we,
  output logic              err
);

  localparam logic [FUNC_W-1:0] F_ADC = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] F_SBC = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] F_ORA = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] F_EOR = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] F_ASL = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] F_LSR = FUNC_W'(6);
  localparam logic [FUNC_W-1:0] F_ROL = FUNC_W'(7);
  localparam logic [FUNC_W-1:0] F_ROR = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] F_CMP = FUNC_W'(9);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_BCD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Handshake and result registers
  logic              r_in_ready;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_dout;
  logic [3:0]        r_flags;
  logic [3:0]        r_we;
  logic              r_err;

  // Latched operation
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [FUNC_W-1:0] r_func;
  logic              r_c;

  // Binary datapath
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin;
  logic [WIDTH:0]    w_sum;
  logic              w_v;
  logic [WIDTH-1:0]  w_res;
  logic              w_c;
  logic [3:0]        w_we;
  logic              w_err;
  logic [3:0]        w_flags;

  // Result load selection
  logic              w_accept;
  logic              w_is_dec;
  logic              w_load;
  logic [WIDTH-1:0]  w_ld_dout;
  logic [3:0]        w_ld_flags;
  logic [3:0]        w_ld_we;
  logic              w_ld_err;

  assign w_accept  = in_valid && r_in_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign flags     = r_flags;
  assign flag_we   = r_we;
  assign err       = r_err;

`ifdef ALU_BCD_EN
  localparam int CNT_W = (WIDTH / 4 > 1) ? $clog2(WIDTH / 4) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(WIDTH / 4 - 1);

  logic              r_dec;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cy;
  logic [WIDTH-1:0]  r_acc;
  logic [2:0]        r_nvz;

  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [4:0]        w_sum_nib;
  logic [3:0]        w_nib;
  logic              w_cy_next;
  logic              w_c_dec;
  logic              w_last;
  logic [WIDTH-1:0]  w_acc_next;

  assign w_is_dec   = r_dec && ((r_func == F_ADC) || (r_func == F_SBC));
  assign w_a_nib    = 4'(r_a >> {r_cnt, 2'b00});
  assign w_b_nib    = 4'(r_b >> {r_cnt, 2'b00});
  assign w_last     = (r_cnt == LAST_NIB);
  assign w_acc_next = r_acc | (WIDTH'(w_nib) << {r_cnt, 2'b00});
  // SBC carries a borrow in r_cy, so its final C is the inverted borrow
  assign w_c_dec    = (r_func == F_SBC) ? ~w_cy_next : w_cy_next;
  assign w_load     = ((r_state == S_EXEC) && !w_is_dec) ||
                      ((r_state == S_BCD) && w_last);

  // Decimal adjust of the current nibble (carry for ADC, borrow for SBC)
  always_comb begin
    w_sum_nib = 5'd0;
    w_nib     = 4'd0;
    w_cy_next = 1'b0;
    if (r_func == F_SBC) begin
      w_sum_nib = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'd0, r_cy};
      if (w_sum_nib[4]) begin
        w_nib     = w_sum_nib[3:0] - 4'd6;
        w_cy_next = 1'b1;
      end else begin
        w_nib     = w_sum_nib[3:0];
        w_cy_next = 1'b0;
      end
    end else begin
      w_sum_nib = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'd0, r_cy};
      if (w_sum_nib > 5'd9) begin
        w_nib     = w_sum_nib[3:0] + 4'd6;
        w_cy_next = 1'b1;
      end else begin
        w_nib     = w_sum_nib[3:0];
        w_cy_next = 1'b0;
      end
    end
  end

  // Decimal-path state: nibble counter, carry/borrow, partial result
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      r_dec <= 1'b0;
      r_cnt <= '0;
      r_cy  <= 1'b0;
      r_acc <= '0;
      r_nvz <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dec <= dec_mode;
          end
        end
        S_EXEC: begin
          if (w_is_dec) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_cy  <= (r_func == F_SBC) ? ~r_c : r_c;
            r_nvz <= w_flags[3:1];
          end
        end
        S_BCD: begin
          r_cy  <= w_cy_next;
          r_acc <= w_acc_next;
          if (w_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end
`else
  logic w_unused_dec;
  assign w_unused_dec = dec_mode;
  assign w_is_dec     = 1'b0;
  assign w_load       = (r_state == S_EXEC);
`endif

  // SBC and CMP add the inverted operand; CMP always carries in 1
  always_comb begin
    w_b_eff = r_b;
    w_cin   = r_c;
    if ((r_func == F_SBC) || (r_func == F_CMP)) begin
      w_b_eff = ~r_b;
    end else begin
      w_b_eff = r_b;
    end
    if (r_func == F_CMP) begin
      w_cin = 1'b1;
    end else begin
      w_cin = r_c;
    end
  end

  assign w_sum = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
  assign w_v   = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  // Binary result, carry and flag-write mask per function
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_we  = 4'b0000;
    w_err = 1'b0;
    case (r_func)
      F_ADC, F_SBC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_we  = 4'b1111;
      end
      F_CMP: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_we  = 4'b1011;
      end
      F_AND: begin
        w_res = r_a & r_b;
        w_we  = 4'b1010;
      end
      F_ORA: begin
        w_res = r_a | r_b;
        w_we  = 4'b1010;
      end
      F_EOR: begin
        w_res = r_a ^ r_b;
        w_we  = 4'b1010;
      end
      F_ASL: begin
        w_res = {r_a[WIDTH-2:0], 1'b0};
        w_c   = r_a[WIDTH-1];
        w_we  = 4'b1011;
      end
      F_ROL: begin
        w_res = {r_a[WIDTH-2:0], r_c};
        w_c   = r_a[WIDTH-1];
        w_we  = 4'b1011;
      end
      F_LSR: begin
        w_res = {1'b0, r_a[WIDTH-1:1]};
        w_c   = r_a[0];
        w_we  = 4'b1011;
      end
      F_ROR: begin
        w_res = {r_c, r_a[WIDTH-1:1]};
        w_c   = r_a[0];
        w_we  = 4'b1011;
      end
      default: begin
        w_res = '0;
        w_c   = 1'b0;
        w_we  = 4'b0000;
        w_err = 1'b1;
      end
    endcase
  end

  // Flags not written by this op read as 0
  assign w_flags = {w_res[WIDTH-1], w_v, (w_res == '0), w_c} & w_we;

  // Pick what lands in the output registers: binary result or BCD result
  always_comb begin
    w_ld_dout  = w_res;
    w_ld_flags = w_flags;
    w_ld_we    = w_we;
    w_ld_err   = w_err;
`ifdef ALU_BCD_EN
    if (r_state == S_BCD) begin
      w_ld_dout  = w_acc_next;
      w_ld_flags = {r_nvz, w_c_dec};
      w_ld_we    = 4'b1111;
      w_ld_err   = 1'b0;
    end else begin
      w_ld_dout  = w_res;
      w_ld_flags = w_flags;
      w_ld_we    = w_we;
      w_ld_err   = w_err;
    end
`endif
  end

  // Next-state logic for the operation sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_is_dec) begin
          w_next_state = S_BCD;
        end else begin
          w_next_state = S_DONE;
        end
      end
`ifdef ALU_BCD_EN
      S_BCD: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_BCD;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake outputs, operand latch and held result registers
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_flags     <= 4'b0000;
      r_we        <= 4'b0000;
      r_err       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_func      <= '0;
      r_c         <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_func <= func;
        r_c    <= carry_in;
      end
      if (w_load) begin
        r_dout  <= w_ld_dout;
        r_flags <= w_ld_flags;
        r_we    <= w_ld_we;
        r_err   <= w_ld_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: one WIDTH=8 and one WIDTH=16 instance,
// an integer reference model feeding a scoreboard queue.
module tb_alu_seq;

`ifdef ALU_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  logic        phi1 = 1'b0;
  logic        reset;
  logic        in_valid8, in_valid16;
  logic        out_ready;
  logic [15:0] a_s, b_s;
  logic [3:0]  func_s;
  logic        carry_s, dec_s;

  logic        in_ready8, out_valid8, err8;
  logic [7:0]  dout8;
  logic [3:0]  flags8, we8;
  logic        in_ready16, out_valid16, err16;
  logic [15:0] dout16;
  logic [3:0]  flags16, we16;

  typedef struct {
    logic [15:0] dout;
    logic [3:0]  flags;
    logic [3:0]  we;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 phi1 = ~phi1;

  alu_seq #(.WIDTH(8), .FUNC_W(4)) u_dut8 (
    .phi1(phi1), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a_s[7:0]), .b(b_s[7:0]), .func(func_s), .carry_in(carry_s),
    .dec_mode(dec_s), .out_valid(out_valid8), .out_ready(out_ready),
    .dout(dout8), .flags(flags8), .flag_we(we8), .err(err8)
  );

  alu_seq #(.WIDTH(16), .FUNC_W(4)) u_dut16 (
    .phi1(phi1), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a_s), .b(b_s), .func(func_s), .carry_in(carry_s),
    .dec_mode(dec_s), .out_valid(out_valid16), .out_ready(out_ready),
    .dout(dout16), .flags(flags16), .flag_we(we16), .err(err16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit wide, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic [3:0] tf, input logic tc, input logic td);
    exp_t e;
    int w, msk, ai, bi, bx, r, s, cy, res, an, bn;
    logic n, v, z, c;
    w = wide ? 16 : 8;
    msk = (1 << w) - 1;
    ai = int'(ta) & msk;
    bi = int'(tb) & msk;
    r = 0; v = 1'b0; c = 1'b0;
    e.we = 4'b0000; e.err = 1'b0; e.lat = 2;
    case (tf)
      4'd0, 4'd1, 4'd9: begin
        bx = (tf == 4'd0) ? bi : (~bi & msk);
        r  = ai + bx + ((tf == 4'd9) ? 1 : int'(tc));
        c  = ((r >> w) & 1) != 0;
        r  = r & msk;
        v  = (((ai >> (w-1)) & 1) == ((bx >> (w-1)) & 1)) &&
             (((r >> (w-1)) & 1) != ((ai >> (w-1)) & 1));
        e.we = (tf == 4'd9) ? 4'b1011 : 4'b1111;
      end
      4'd2: begin r = ai & bi; e.we = 4'b1010; end
      4'd3: begin r = ai | bi; e.we = 4'b1010; end
      4'd4: begin r = ai ^ bi; e.we = 4'b1010; end
      4'd5: begin r = (ai << 1) & msk; c = ((ai >> (w-1)) & 1) != 0; e.we = 4'b1011; end
      4'd6: begin r = ai >> 1; c = (ai & 1) != 0; e.we = 4'b1011; end
      4'd7: begin r = ((ai << 1) | int'(tc)) & msk; c = ((ai >> (w-1)) & 1) != 0; e.we = 4'b1011; end
      4'd8: begin r = (ai >> 1) | (int'(tc) << (w-1)); c = (ai & 1) != 0; e.we = 4'b1011; end
      default: begin r = 0; e.err = 1'b1; e.we = 4'b0000; end
    endcase
    n = ((r >> (w-1)) & 1) != 0;
    z = (r == 0);
    e.dout  = 16'(r);
    e.flags = {n, v, z, c} & e.we;
    if (BCD_ON && td && (tf <= 4'd1)) begin
      cy  = (tf == 4'd0) ? int'(tc) : 1 - int'(tc);
      res = 0;
      for (int i = 0; i < w / 4; i++) begin
        an = (ai >> (4 * i)) & 15;
        bn = (bi >> (4 * i)) & 15;
        if (tf == 4'd0) begin
          s = an + bn + cy;
          if (s > 9) begin s = s + 6; cy = 1; end else cy = 0;
        end else begin
          s = an - bn - cy;
          if (s < 0) begin s = s - 6; cy = 1; end else cy = 0;
        end
        res = res | ((s & 15) << (4 * i));
      end
      e.dout     = 16'(res);
      e.flags[0] = (tf == 4'd0) ? (cy != 0) : (cy == 0);
      e.lat      = 2 + w / 4;
    end
    return e;
  endfunction

  function automatic logic o_valid(input bit wide);
    return wide ? out_valid16 : out_valid8;
  endfunction

  function automatic logic i_ready(input bit wide);
    return wide ? in_ready16 : in_ready8;
  endfunction

  function automatic logic [24:0] o_res(input bit wide);
    return wide ? {err16, we16, flags16, dout16} : {err8, we8, flags8, 8'h00, dout8};
  endfunction

  // Issue one op (called right after a negedge), score it, optionally stall the pop
  task automatic run_op(input bit wide, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [3:0] tf, input logic tc, input logic td, input int hold);
    exp_t e;
    int   lat;
    a_s = ta; b_s = tb; func_s = tf; carry_s = tc; dec_s = td;
    chk("in_ready_before", 32'(i_ready(wide)), 32'd1);
    if (wide) in_valid16 = 1'b1; else in_valid8 = 1'b1;
    sb_q.push_back(model(wide, ta, tb, tf, tc, td));
    @(negedge phi1);
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    chk("in_ready_busy", 32'(i_ready(wide)), 32'd0);
    lat = 1;
    while (!o_valid(wide) && lat < 40) begin
      @(negedge phi1);
      lat++;
    end
    e = sb_q.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("dout", 32'(o_res(wide)) & 32'hFFFF, 32'(e.dout));
    chk("flags", 32'(o_res(wide) >> 16) & 32'hF, 32'(e.flags));
    chk("flag_we", 32'(o_res(wide) >> 20) & 32'hF, 32'(e.we));
    chk("err", 32'(o_res(wide) >> 24), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      a_s = ~ta; b_s = ~tb;
      if (wide) in_valid16 = 1'b1; else in_valid8 = 1'b1;
      @(negedge phi1);
      chk("hold_in_ready", 32'(i_ready(wide)), 32'd0);
      chk("hold_out_valid", 32'(o_valid(wide)), 32'd1);
      chk("hold_result", 32'(o_res(wide)), 32'({e.err, e.we, e.flags, e.dout}) & (wide ? 32'h1FFFFFF : 32'h1FF00FF));
    end
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    out_ready = 1'b1;
    @(negedge phi1);
    out_ready = 1'b0;
    chk("pop_out_valid", 32'(o_valid(wide)), 32'd0);
    chk("pop_in_ready", 32'(i_ready(wide)), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    in_valid8 = 1'b0; in_valid16 = 1'b0; out_ready = 1'b0;
    a_s = 16'h0000; b_s = 16'h0000; func_s = 4'd0; carry_s = 1'b0; dec_s = 1'b0;
    repeat (2) @(negedge phi1);
    chk("rst_in_ready8", 32'(in_ready8), 32'd0);
    chk("rst_state8", {23'd0, out_valid8, err8, we8, flags8, dout8} , 32'd0);
    chk("rst_state16", {10'd0, out_valid16, err16, we16, flags16, dout16}, 32'd0);
    reset = 1'b0;
    @(negedge phi1);
    chk("post_rst_in_ready", 32'(in_ready8), 32'd1);

    run_op(1'b0, 16'h0050, 16'h0050, 4'd0, 1'b0, 1'b0, 0);   // ADC overflow
    run_op(1'b0, 16'h0058, 16'h0046, 4'd0, 1'b1, 1'b1, 0);   // decimal ADC
    run_op(1'b0, 16'h0000, 16'h0001, 4'd1, 1'b1, 1'b0, 0);   // SBC wrap
    run_op(1'b0, 16'h0010, 16'h0001, 4'd1, 1'b1, 1'b1, 0);   // decimal SBC borrow
    run_op(1'b0, 16'h0010, 16'h0010, 4'd9, 1'b0, 1'b0, 0);   // CMP equal
    run_op(1'b0, 16'h0005, 16'h0010, 4'd9, 1'b1, 1'b0, 0);   // CMP less
    run_op(1'b0, 16'h00F0, 16'h003C, 4'd2, 1'b0, 1'b0, 0);   // AND
    run_op(1'b0, 16'h0000, 16'h0000, 4'd3, 1'b0, 1'b0, 0);   // ORA zero
    run_op(1'b0, 16'h00AA, 16'h0055, 4'd4, 1'b0, 1'b0, 0);   // EOR
    run_op(1'b0, 16'h0081, 16'h0000, 4'd5, 1'b1, 1'b0, 0);   // ASL
    run_op(1'b0, 16'h0001, 16'h0000, 4'd6, 1'b1, 1'b0, 0);   // LSR
    run_op(1'b0, 16'h0080, 16'h0000, 4'd7, 1'b1, 1'b0, 0);   // ROL
    run_op(1'b0, 16'h0001, 16'h0000, 4'd8, 1'b1, 1'b0, 0);   // ROR
    run_op(1'b0, 16'h0033, 16'h0044, 4'd12, 1'b1, 1'b0, 0);  // invalid
    run_op(1'b0, 16'h0012, 16'h0034, 4'd0, 1'b0, 1'b0, 5);   // held result
    run_op(1'b0, 16'h0007, 16'h0003, 4'd1, 1'b1, 1'b0, 0);   // next op after hold

    // Reset during the first BCD cycle of a decimal ADC
    a_s = 16'h0058; b_s = 16'h0046; func_s = 4'd0; carry_s = 1'b1; dec_s = 1'b1;
    in_valid8 = 1'b1;
    @(negedge phi1);
    in_valid8 = 1'b0;
    @(negedge phi1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid8), 32'd0);
    chk("midrst_dout", 32'(dout8), 32'd0);
    chk("midrst_in_ready", 32'(in_ready8), 32'd0);
    @(negedge phi1);
    reset = 1'b0;
    @(negedge phi1);
    chk("midrst_release_ready", 32'(in_ready8), 32'd1);
    run_op(1'b0, 16'h0001, 16'h0001, 4'd0, 1'b0, 1'b1, 0);

    run_op(1'b1, 16'h9999, 16'h0001, 4'd0, 1'b0, 1'b1, 0);   // 16-bit decimal carry chain
    run_op(1'b1, 16'h1000, 16'h0001, 4'd1, 1'b1, 1'b1, 0);   // 16-bit decimal SBC
    run_op(1'b1, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 1'b0, 0);   // 16-bit binary overflow
    run_op(1'b1, 16'h8001, 16'h0000, 4'd8, 1'b0, 1'b0, 0);   // 16-bit ROR
    run_op(1'b1, 16'h1234, 16'h5678, 4'd12, 1'b0, 1'b0, 0);  // 16-bit invalid

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
